avalon_mm_fifo_buffer_csr: RTL and testbench
============================================

Name: avalon_mm_fifo_buffer_csr

Overview:
- Parametrised single-clock Avalon-MM FIFO bridge between a producer (write slave) and a consumer (read slave).
- Successor to the fixed 16x16 buffer: configurable width and depth, show-ahead read data, fill-level readout, programmable almost-full/almost-empty thresholds, flush, and an interrupt via a CSR slave.
- Sits between a streaming master (e.g. ADC/DMA side) and the HPS bridge in Computer_System.

Parameters:
DATA_WIDTH, 16, FIFO word width (1..32)
DEPTH, 16, number of entries; power of two, >= 2
AW, log2(DEPTH), derived pointer width; not overridden
AFULL_DEFAULT, DEPTH-2, reset value of almost-full threshold
AEMPTY_DEFAULT, 1, reset value of almost-empty threshold

Ports:
wrclock  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
avalonmm_write_slave_write  in  1  push request
avalonmm_write_slave_writedata  in  DATA_WIDTH  push data
avalonmm_write_slave_waitrequest  out  1  push stall
avalonmm_read_slave_read  in  1  pop request
avalonmm_read_slave_readdata  out  DATA_WIDTH  head word (show-ahead)
avalonmm_read_slave_waitrequest  out  1  pop stall
avalonmm_csr_address  in  2  CSR word address
avalonmm_csr_read  in  1  CSR read strobe
avalonmm_csr_write  in  1  CSR write strobe
avalonmm_csr_writedata  in  32  CSR write data
avalonmm_csr_readdata  out  32  CSR read data
irq  out  1  level interrupt, active high

Behaviour:
- Clock and reset: one clock (wrclock); reset is asynchronous and active-low (reset_n).
- Storage: DEPTH x DATA_WIDTH register array.
  - Pointers wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH.
  - fill counter is AW+1 bits, range 0..DEPTH.
- Reset:
  - Pointers, fill and pending bits clear to 0.
  - Thresholds load AFULL_DEFAULT and AEMPTY_DEFAULT.
  - IRQ enables clear to 0; irq = 0.
  - write waitrequest = 1 while reset_n = 0.
  - read waitrequest = 1, because the FIFO is empty.
- Write handshake:
  - write_waitrequest = full (fill == DEPTH).
  - A push occurs when write = 1 and waitrequest = 0; data is stored at wr_ptr and wr_ptr increments next edge.
  - When full, a write stalls even if a pop happens in the same cycle. No same-cycle full bypass.
- Read handshake:
  - read_waitrequest = empty (fill == 0).
  - readdata = mem[rd_ptr] combinationally (0-cycle latency); it is valid whenever not empty.
  - A pop occurs when read = 1 and waitrequest = 0; rd_ptr increments next edge.
  - When empty, the read stalls. A same-cycle write is not forwarded; data becomes readable the cycle after the push.
  - readdata while empty is don't-care. The bench must not check it.
- Simultaneous push and pop (neither full nor empty): fill is unchanged and both pointers advance.
- Flags (combinational from fill and current thresholds):
  - almost_full = fill >= afull_thr.
  - almost_empty = fill <= aempty_thr.
- CSR map (read latency 0, no waitrequest):
  - addr0 FILL (RO): bits[AW:0] = fill; other bits 0.
  - addr1 STATUS:
    - bit0 empty, bit1 full, bit2 almost_empty, bit3 almost_full (RO, live).
    - bit8 afull_pend, bit9 aempty_pend (sticky, write-1-to-clear).
  - addr2 THRESH (RW): [15:0] afull_thr, [31:16] aempty_thr. Unused upper bits of each field read 0; the value is truncated to AW+1 bits.
  - addr3 CONTROL:
    - bit0 afull_irq_en, bit1 aempty_irq_en (RW).
    - bit31 flush (write-only, reads 0).
- Pending bits:
  - afull_pend sets on a 0->1 transition of almost_full.
  - aempty_pend sets on a 0->1 transition of almost_empty.
  - The transition is detected against a registered copy of the flag; that copy resets to almost_empty = 1 and almost_full = 0, so no event occurs at reset.
  - If a set and a W1C land in the same cycle, set wins.
- irq = (afull_pend & afull_irq_en) | (aempty_pend & aempty_irq_en), registered (1 cycle after the pend/enable change).
- Flush (write 1 to CONTROL bit31):
  - Next edge: pointers and fill go to 0.
  - A push or pop in the flush cycle is discarded.
  - Pending bits, thresholds and enables are unaffected.
  - Transition detection still applies, so a flush can set aempty_pend.
- Asynchronous reset mid-transfer aborts all state immediately; there is no partial write.

Test Plan:
- Reset then idle -> read_wr=1; write_wr=0 after release; read_wr=1; FILL=0; irq=0; THRESH reads 0x0001000E (DEPTH=16).
- Push 0x1111, 0x2222, 0x3333, then 3 pops -> readdata 0x1111 visible 1 cycle after the first push, then 0x2222, 0x3333; empty after the third pop.
- Push 16 words with write held high -> write_wr=1 from the cycle after the 16th push; FILL=16; STATUS[1]=1. A 17th write with a simultaneous pop stalls; FILL becomes 15.
- Simultaneous push/pop at fill 5 for 20 cycles -> FILL stays 5; data order preserved through pointer wrap.
- Set THRESH afull=4, CONTROL=0x1, push 4 words -> STATUS[8]=1 and irq=1 one cycle later. W1C of 0x100 -> irq=0. Pushing a 5th word gives no new pend.
- Fill 7 words, write CONTROL=0x80000000 with a concurrent push -> FILL=0 next cycle; the push is lost; aempty_pend=1.

Source files
------------

// File: rtl/avalon_mm_fifo_buffer_csr.sv
// Single-clock Avalon-MM FIFO bridge with show-ahead read data, fill-level
// readout, programmable almost-full/almost-empty thresholds, flush and a
// level interrupt driven from sticky pending bits.
module avalon_mm_fifo_buffer_csr #(
    parameter int DATA_WIDTH     = 16,
    parameter int DEPTH          = 16,
    parameter int AFULL_DEFAULT  = DEPTH - 2,
    parameter int AEMPTY_DEFAULT = 1
) (
    input  logic                  wrclock,
    input  logic                  reset_n,
    input  logic                  avalonmm_write_slave_write,
    input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
    output logic                  avalonmm_write_slave_waitrequest,
    input  logic                  avalonmm_read_slave_read,
    output logic [DATA_WIDTH-1:0] avalonmm_read_slave_readdata,
    output logic                  avalonmm_read_slave_waitrequest,
    input  logic [1:0]            avalonmm_csr_address,
    input  logic                  avalonmm_csr_read,
    input  logic                  avalonmm_csr_write,
    input  logic [31:0]           avalonmm_csr_writedata,
    output logic [31:0]           avalonmm_csr_readdata,
    output logic                  irq
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           fill_q, fill_d;
    logic [AW:0]           afull_thr_q, afull_thr_d;
    logic [AW:0]           aempty_thr_q, aempty_thr_d;
    logic                  afull_en_q, afull_en_d;
    logic                  aempty_en_q, aempty_en_d;
    logic                  afull_pend_q, afull_pend_d;
    logic                  aempty_pend_q, aempty_pend_d;
    logic                  afull_prev_q, afull_prev_d;
    logic                  aempty_prev_q, aempty_prev_d;
    logic                  irq_q, irq_d;

    logic                  full_s, empty_s, push_s, pop_s, flush_s;
    logic                  almost_full_s, almost_empty_s;
    logic                  wr_status_s, wr_thresh_s, wr_ctrl_s;
    logic [31:0]           csr_rdata_s;
    logic                  unused_wdata_s;

    // Handshake decode, flags and CSR write strobes
    always_comb begin
        full_s         = (fill_q == (AW+1)'(DEPTH));
        empty_s        = (fill_q == '0);
        push_s         = avalonmm_write_slave_write & ~full_s;
        pop_s          = avalonmm_read_slave_read & ~empty_s;
        almost_full_s  = (fill_q >= afull_thr_q);
        almost_empty_s = (fill_q <= aempty_thr_q);
        wr_status_s    = avalonmm_csr_write & (avalonmm_csr_address == 2'd1);
        wr_thresh_s    = avalonmm_csr_write & (avalonmm_csr_address == 2'd2);
        wr_ctrl_s      = avalonmm_csr_write & (avalonmm_csr_address == 2'd3);
        flush_s        = wr_ctrl_s & avalonmm_csr_writedata[31];
    end

    // Storage write: a push writes at wr_ptr unless a flush discards it
    always_comb begin
        mem_d = mem_q;
        if (push_s && !flush_s) begin
            mem_d[wr_ptr_q] = avalonmm_write_slave_writedata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Pointer and fill update; flush overrides any concurrent push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   fill_d = fill_q + (AW+1)'(1);
                2'b01:   fill_d = fill_q - (AW+1)'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    // CSR configuration, pending bits (set beats W1C) and irq
    always_comb begin
        afull_thr_d   = afull_thr_q;
        aempty_thr_d  = aempty_thr_q;
        afull_en_d    = afull_en_q;
        aempty_en_d   = aempty_en_q;
        if (wr_thresh_s) begin
            afull_thr_d  = avalonmm_csr_writedata[AW:0];
            aempty_thr_d = avalonmm_csr_writedata[16+AW:16];
        end else begin
            afull_thr_d  = afull_thr_q;
            aempty_thr_d = aempty_thr_q;
        end
        if (wr_ctrl_s) begin
            afull_en_d  = avalonmm_csr_writedata[0];
            aempty_en_d = avalonmm_csr_writedata[1];
        end else begin
            afull_en_d  = afull_en_q;
            aempty_en_d = aempty_en_q;
        end
        afull_prev_d  = almost_full_s;
        aempty_prev_d = almost_empty_s;
        afull_pend_d  = (afull_pend_q & ~(wr_status_s & avalonmm_csr_writedata[8]))
                      | (almost_full_s & ~afull_prev_q);
        aempty_pend_d = (aempty_pend_q & ~(wr_status_s & avalonmm_csr_writedata[9]))
                      | (almost_empty_s & ~aempty_prev_q);
        irq_d         = (afull_pend_q & afull_en_q) | (aempty_pend_q & aempty_en_q);
    end

    // CSR read mux, zero latency; drives zero when not reading
    always_comb begin
        csr_rdata_s = 32'h0000_0000;
        if (avalonmm_csr_read) begin
            case (avalonmm_csr_address)
                2'd0: csr_rdata_s[AW:0] = fill_q;
                2'd1: begin
                    csr_rdata_s[0] = empty_s;
                    csr_rdata_s[1] = full_s;
                    csr_rdata_s[2] = almost_empty_s;
                    csr_rdata_s[3] = almost_full_s;
                    csr_rdata_s[8] = afull_pend_q;
                    csr_rdata_s[9] = aempty_pend_q;
                end
                2'd2: begin
                    csr_rdata_s[AW:0]     = afull_thr_q;
                    csr_rdata_s[16+AW:16] = aempty_thr_q;
                end
                2'd3: csr_rdata_s[1:0] = {aempty_en_q, afull_en_q};
                default: csr_rdata_s = 32'h0000_0000;
            endcase
        end else begin
            csr_rdata_s = 32'h0000_0000;
        end
    end

    // State registers; flag history resets to the idle (empty) levels
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            afull_thr_q   <= (AW+1)'(AFULL_DEFAULT);
            aempty_thr_q  <= (AW+1)'(AEMPTY_DEFAULT);
            afull_en_q    <= 1'b0;
            aempty_en_q   <= 1'b0;
            afull_pend_q  <= 1'b0;
            aempty_pend_q <= 1'b0;
            afull_prev_q  <= 1'b0;
            aempty_prev_q <= 1'b1;
            irq_q         <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            afull_thr_q   <= afull_thr_d;
            aempty_thr_q  <= aempty_thr_d;
            afull_en_q    <= afull_en_d;
            aempty_en_q   <= aempty_en_d;
            afull_pend_q  <= afull_pend_d;
            aempty_pend_q <= aempty_pend_d;
            afull_prev_q  <= afull_prev_d;
            aempty_prev_q <= aempty_prev_d;
            irq_q         <= irq_d;
        end
    end

    assign unused_wdata_s                   = ^avalonmm_csr_writedata;
    assign avalonmm_write_slave_waitrequest = ~reset_n | full_s;
    assign avalonmm_read_slave_waitrequest  = empty_s;
    assign avalonmm_read_slave_readdata     = mem_q[rd_ptr_q];
    assign avalonmm_csr_readdata            = csr_rdata_s;
    assign irq                              = irq_q;

endmodule

// File: tb/tb_avalon_mm_fifo_buffer_csr.sv
// Directed bench for avalon_mm_fifo_buffer_csr (DATA_WIDTH=16, DEPTH=16).
module tb_avalon_mm_fifo_buffer_csr;

    logic        clk;
    logic        reset_n;
    logic        wr;
    logic [15:0] wdata;
    logic        wr_wait;
    logic        rd;
    logic [15:0] rdata;
    logic        rd_wait;
    logic [1:0]  caddr;
    logic        cread;
    logic        cwrite;
    logic [31:0] cwdata;
    logic [31:0] crdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    avalon_mm_fifo_buffer_csr #(.DATA_WIDTH(16), .DEPTH(16)) dut (
        .wrclock                          (clk),
        .reset_n                          (reset_n),
        .avalonmm_write_slave_write       (wr),
        .avalonmm_write_slave_writedata   (wdata),
        .avalonmm_write_slave_waitrequest (wr_wait),
        .avalonmm_read_slave_read         (rd),
        .avalonmm_read_slave_readdata     (rdata),
        .avalonmm_read_slave_waitrequest  (rd_wait),
        .avalonmm_csr_address             (caddr),
        .avalonmm_csr_read                (cread),
        .avalonmm_csr_write               (cwrite),
        .avalonmm_csr_writedata           (cwdata),
        .avalonmm_csr_readdata            (crdata),
        .irq                              (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        caddr = a;
        cread = 1'b1;
        #1;
        d     = crdata;
        cread = 1'b0;
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        caddr  = a;
        cwdata = d;
        cwrite = 1'b1;
        tick();
        cwrite = 1'b0;
    endtask

    logic [31:0] v;

    initial begin
        reset_n = 1'b0; wr = 1'b0; wdata = 16'h0; rd = 1'b0;
        caddr = 2'd0; cread = 1'b0; cwrite = 1'b0; cwdata = 32'h0;

        // Reset state
        #2;
        chk("rst_wr_wait", {31'h0, wr_wait}, 32'h1);
        chk("rst_rd_wait", {31'h0, rd_wait}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("idle_wr_wait", {31'h0, wr_wait}, 32'h0);
        chk("idle_rd_wait", {31'h0, rd_wait}, 32'h1);
        csr_rd(2'd0, v); chk("idle_fill", v, 32'h0);
        csr_rd(2'd2, v); chk("idle_thresh", v, 32'h0001_000E);
        csr_rd(2'd1, v); chk("idle_status", v, 32'h0000_0005);
        tick();
        chk("idle_irq", {31'h0, irq}, 32'h0);

        // Three pushes then three pops, show-ahead order
        wr = 1'b1; wdata = 16'h1111; tick();
        chk("sa_first", {16'h0, rdata}, 32'h1111);
        chk("sa_rd_wait", {31'h0, rd_wait}, 32'h0);
        wdata = 16'h2222; tick();
        wdata = 16'h3333; tick();
        wr = 1'b0; rd = 1'b1;
        chk("pop1", {16'h0, rdata}, 32'h1111); tick();
        chk("pop2", {16'h0, rdata}, 32'h2222); tick();
        chk("pop3", {16'h0, rdata}, 32'h3333); tick();
        rd = 1'b0;
        chk("pop_empty", {31'h0, rd_wait}, 32'h1);
        csr_rd(2'd0, v); chk("pop_fill", v, 32'h0);

        // Fill to full, then a write stalls against a concurrent pop
        wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wdata = 16'h0100 + 16'(i);
            tick();
        end
        chk("full_wr_wait", {31'h0, wr_wait}, 32'h1);
        csr_rd(2'd0, v); chk("full_fill", v, 32'd16);
        csr_rd(2'd1, v); chk("full_status_bit1", {31'h0, v[1]}, 32'h1);
        wdata = 16'hDEAD; rd = 1'b1;
        chk("full_head", {16'h0, rdata}, 32'h0100);
        tick();
        wr = 1'b0; rd = 1'b0;
        csr_rd(2'd0, v); chk("stall_fill", v, 32'd15);
        rd = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk("drain", {16'h0, rdata}, 32'h0101 + 32'(i));
            tick();
        end
        rd = 1'b0;
        chk("drain_empty", {31'h0, rd_wait}, 32'h1);

        // Steady push/pop at fill 5 across pointer wrap
        wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 16'h0200 + 16'(i);
            tick();
        end
        rd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wdata = 16'h0205 + 16'(k);
            chk("stream_head", {16'h0, rdata}, 32'h0200 + 32'(k));
            tick();
        end
        wr = 1'b0;
        csr_rd(2'd0, v); chk("stream_fill", v, 32'd5);
        for (int k = 20; k < 25; k++) begin
            chk("stream_tail", {16'h0, rdata}, 32'h0200 + 32'(k));
            tick();
        end
        rd = 1'b0;

        // Almost-full interrupt, W1C, no re-trigger while high
        csr_wr(2'd1, 32'h0000_0300);
        csr_wr(2'd2, 32'h0001_0004);
        csr_wr(2'd3, 32'h0000_0001);
        csr_rd(2'd1, v); chk("af_status_clean", v, 32'h0000_0005);
        wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = 16'h0300 + 16'(i);
            tick();
        end
        wr = 1'b0;
        csr_rd(2'd1, v); chk("af_live_flag", v, 32'h0000_0008);
        tick();
        csr_rd(2'd1, v); chk("af_pend_set", v, 32'h0000_0108);
        chk("af_irq_lag", {31'h0, irq}, 32'h0);
        tick();
        chk("af_irq", {31'h0, irq}, 32'h1);
        csr_wr(2'd1, 32'h0000_0100);
        csr_rd(2'd1, v); chk("af_w1c", v, 32'h0000_0008);
        tick();
        chk("af_irq_clr", {31'h0, irq}, 32'h0);
        wr = 1'b1; wdata = 16'h0304; tick(); wr = 1'b0;
        tick();
        csr_rd(2'd1, v); chk("af_no_repend", v, 32'h0000_0008);
        chk("af_irq_quiet", {31'h0, irq}, 32'h0);

        // Flush at fill 7 with a concurrent push
        wr = 1'b1;
        wdata = 16'h0305; tick();
        wdata = 16'h0306; tick();
        wr = 1'b0;
        csr_rd(2'd0, v); chk("pre_flush_fill", v, 32'd7);
        wr = 1'b1; wdata = 16'hBEEF;
        csr_wr(2'd3, 32'h8000_0000);
        wr = 1'b0;
        csr_rd(2'd0, v); chk("flush_fill", v, 32'h0);
        chk("flush_rd_wait", {31'h0, rd_wait}, 32'h1);
        tick();
        csr_rd(2'd1, v); chk("flush_status", v, 32'h0000_0205);
        csr_rd(2'd3, v); chk("ctrl_readback", v, 32'h0);
        wr = 1'b1; wdata = 16'h0400; tick(); wr = 1'b0;
        chk("post_flush_head", {16'h0, rdata}, 32'h0400);
        csr_rd(2'd0, v); chk("post_flush_fill", v, 32'd1);
        csr_rd(2'd2, v); chk("thresh_kept", v, 32'h0001_0004);

        // Threshold truncation to AW+1 bits
        csr_wr(2'd2, 32'hFFFF_FFFF);
        csr_rd(2'd2, v); chk("thresh_trunc", v, 32'h001F_001F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
